collision_wall_multi: RTL and testbench



---
 rtl/collision_wall_multi_pkg.sv | 23 ++
 rtl/collision_wall_multi_edge_acc.sv | 127 ++++++++++++
 rtl/collision_wall_multi.sv | 114 +++++++++++
 tb/tb_collision_wall_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_wall_multi_pkg.sv
// Shared types and default constants for the multi-object wall collision detector.
package collision_pkg;

  localparam int unsigned NUM_OBJ_DEF  = 4;
  localparam int unsigned COORD_W_DEF  = 10;
  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } coll_state_t;

  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
  } edge_flags_t;

endpackage

// File: rtl/collision_wall_multi_edge_acc.sv
// Per-object collision tracker: frame snapshot of the bounding box, outline
// compare against the pipelined raster pixel, sticky edge accumulator,
// committed flags, last collision-free position.
// Optional: COLLISION_COUNT_EN adds a saturating per-object hit counter.
module collision_edge_acc
  import collision_pkg::*;
#(
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_commit,
  input  logic               i_scan_en,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic               i_wall,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_s,
  input  logic               i_active,
  output edge_flags_t        o_flags,
  output logic [COORD_W-1:0] o_prev_x,
`ifdef COLLISION_COUNT_EN
  output logic [CNT_W-1:0]   o_hit_count,
`endif
  output logic [COORD_W-1:0] o_prev_y
);

  // Two extra bits: sign plus headroom so X+S never wraps even at full-scale inputs.
  localparam int unsigned SW = COORD_W + 2;
  localparam logic signed [SW-1:0] C_ZERO  = '0;
  localparam logic signed [SW-1:0] C_BOT   = SW'(SCREEN_H - 1);
  localparam logic signed [SW-1:0] C_RIGHT = SW'(SCREEN_W - 1);

  logic [COORD_W-1:0] r_x, r_y, r_s;
  logic               r_active;
  edge_flags_t        r_acc;
  edge_flags_t        r_flags;
  logic [COORD_W-1:0] r_prev_x, r_prev_y;

  logic signed [SW-1:0] w_xl, w_xh, w_yl, w_yh, w_px, w_py;
  logic                 w_in_x, w_in_y;
  edge_flags_t          w_hit, w_scr, w_new;

  // Box edges, outline hits for the current pixel, screen-border flags.
  always_comb begin
    w_xl   = $signed({2'b00, r_x}) - $signed({2'b00, r_s});
    w_xh   = $signed({2'b00, r_x}) + $signed({2'b00, r_s});
    w_yl   = $signed({2'b00, r_y}) - $signed({2'b00, r_s});
    w_yh   = $signed({2'b00, r_y}) + $signed({2'b00, r_s});
    w_px   = $signed({2'b00, i_px});
    w_py   = $signed({2'b00, i_py});
    w_in_x = (w_px >= w_xl) && (w_px <= w_xh);
    w_in_y = (w_py >= w_yl) && (w_py <= w_yh);

    w_hit        = '0;
    w_hit.top    = i_wall && r_active && (w_py == w_yl) && w_in_x;
    w_hit.bottom = i_wall && r_active && (w_py == w_yh) && w_in_x;
    w_hit.left   = i_wall && r_active && (w_px == w_xl) && w_in_y;
    w_hit.right  = i_wall && r_active && (w_px == w_xh) && w_in_y;

    w_scr        = '0;
    w_scr.top    = r_active && (w_yl <= C_ZERO);
    w_scr.bottom = r_active && (w_yh >= C_BOT);
    w_scr.left   = r_active && (w_xl <= C_ZERO);
    w_scr.right  = r_active && (w_xh >= C_RIGHT);

    w_new = r_active ? (r_acc | w_scr) : '0;
  end

  // Snapshot at frame start, sticky accumulation during the scan.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_s      <= '0;
      r_active <= 1'b0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_x      <= i_x;
      r_y      <= i_y;
      r_s      <= i_s;
      r_active <= i_active;
      r_acc    <= '0;
    end else if (i_scan_en) begin
      r_acc    <= r_acc | w_hit;
    end
  end

  // Commit flags; remember the position of a clean frame for rollback.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flags  <= '0;
      r_prev_x <= '0;
      r_prev_y <= '0;
    end else if (i_commit) begin
      r_flags <= w_new;
      if (r_active && (w_new == '0)) begin
        r_prev_x <= r_x;
        r_prev_y <= r_y;
      end
    end
  end

`ifdef COLLISION_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of frames that committed any flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_commit && (w_new != '0) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit_count = r_cnt;
`endif

  assign o_flags  = r_flags;
  assign o_prev_x = r_prev_x;
  assign o_prev_y = r_prev_y;

endmodule

// File: rtl/collision_wall_multi.sv
// Multi-object wall collision detector: frame-start detect, one-stage pixel
// pipeline, IDLE/SCAN/COMMIT sequencing, one tracker per object.
// Optional: COLLISION_COUNT_EN adds hit_count (8 bits per object).
module collision_wall_multi
  import collision_pkg::*;
#(
  parameter int unsigned NUM_OBJ  = NUM_OBJ_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic                       pixel_clk,
  input  logic                       Reset,
  input  logic [COORD_W-1:0]         draw_x,
  input  logic [COORD_W-1:0]         draw_y,
  input  logic                       wall_pixel,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_s,
  input  logic [NUM_OBJ-1:0]         obj_active,
  output logic [NUM_OBJ-1:0]         wall_top,
  output logic [NUM_OBJ-1:0]         wall_bottom,
  output logic [NUM_OBJ-1:0]         wall_left,
  output logic [NUM_OBJ-1:0]         wall_right,
  output logic [NUM_OBJ*COORD_W-1:0] prev_x,
  output logic [NUM_OBJ*COORD_W-1:0] prev_y,
`ifdef COLLISION_COUNT_EN
  output logic [NUM_OBJ*CNT_W-1:0]   hit_count,
`endif
  output logic                       result_valid
);

  coll_state_t        r_state;
  logic               r_valid;
  logic               r_at00, r_fs;
  logic [COORD_W-1:0] r_px, r_py;
  logic               r_wall;
  logic               w_at00, w_load, w_commit, w_scan;

  assign w_at00 = (draw_x == '0) && (draw_y == '0);

  // Frame-start edge detect and pixel pipeline stage.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      r_at00 <= 1'b0;
      r_fs   <= 1'b0;
      r_px   <= '0;
      r_py   <= '0;
      r_wall <= 1'b0;
    end else begin
      r_at00 <= w_at00;
      r_fs   <= w_at00 && !r_at00;
      r_px   <= draw_x;
      r_py   <= draw_y;
      r_wall <= wall_pixel;
    end
  end

  // Frame sequencing; result_valid rises together with the committed outputs.
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == COMMIT);
      case (r_state)
        IDLE:    if (r_fs) r_state <= SCAN;
        SCAN:    if (r_fs) r_state <= COMMIT;
        COMMIT:  r_state <= SCAN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_load       = ((r_state == IDLE) && r_fs) || (r_state == COMMIT);
  assign w_commit     = (r_state == COMMIT);
  assign w_scan       = (r_state == SCAN);
  assign result_valid = r_valid;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    edge_flags_t w_flags;

    collision_edge_acc #(
      .COORD_W  (COORD_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
    ) u_acc (
      .i_clk       (pixel_clk),
      .i_rst       (Reset),
      .i_load      (w_load),
      .i_commit    (w_commit),
      .i_scan_en   (w_scan),
      .i_px        (r_px),
      .i_py        (r_py),
      .i_wall      (r_wall),
      .i_x         (obj_x[g*COORD_W +: COORD_W]),
      .i_y         (obj_y[g*COORD_W +: COORD_W]),
      .i_s         (obj_s[g*COORD_W +: COORD_W]),
      .i_active    (obj_active[g]),
      .o_flags     (w_flags),
      .o_prev_x    (prev_x[g*COORD_W +: COORD_W]),
`ifdef COLLISION_COUNT_EN
      .o_hit_count (hit_count[g*CNT_W +: CNT_W]),
`endif
      .o_prev_y    (prev_y[g*COORD_W +: COORD_W])
    );

    assign wall_top[g]    = w_flags.top;
    assign wall_bottom[g] = w_flags.bottom;
    assign wall_left[g]   = w_flags.left;
    assign wall_right[g]  = w_flags.right;
  end

endmodule

// File: tb/tb_collision_wall_multi.sv
// Bench for collision_wall_multi: table of frames with expected commits,
// scoreboard queue popped on result_valid, hand-written reset sequence and,
// with COLLISION_COUNT_EN, counter saturation.
module tb_collision_wall_multi;

  logic        pixel_clk = 1'b0;
  logic        Reset;
  logic [9:0]  draw_x, draw_y;
  logic        wall_pixel;
  logic [39:0] obj_x, obj_y, obj_s;
  logic [3:0]  obj_active;
  logic [3:0]  wall_top, wall_bottom, wall_left, wall_right;
  logic [39:0] prev_x, prev_y;
  logic        result_valid;
`ifdef COLLISION_COUNT_EN
  logic [31:0] hit_count;
`endif

  collision_wall_multi #(
    .NUM_OBJ  (4),
    .COORD_W  (10),
    .SCREEN_W (640),
    .SCREEN_H (480)
  ) dut (
    .pixel_clk    (pixel_clk),
    .Reset        (Reset),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .wall_pixel   (wall_pixel),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_s        (obj_s),
    .obj_active   (obj_active),
    .wall_top     (wall_top),
    .wall_bottom  (wall_bottom),
    .wall_left    (wall_left),
    .wall_right   (wall_right),
    .prev_x       (prev_x),
    .prev_y       (prev_y),
`ifdef COLLISION_COUNT_EN
    .hit_count    (hit_count),
`endif
    .result_valid (result_valid)
  );

  always #5 pixel_clk = ~pixel_clk;

  // One frame of stimulus and the commit it must produce (flags as {t,b,l,r}).
  typedef struct {
    int x0, y0, s0; bit a0;
    int x1, y1, s1; bit a1;
    int wx, wy, chg;
    logic [3:0] f0, f1;
    int p0x, p0y, p1x, p1y;
  } vec_t;

  typedef struct {
    logic [3:0]  top, bot, lft, rgt;
    logic [39:0] px, py;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  bit   valid_d = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard side: every result_valid pulse consumes one expected commit.
  always @(negedge pixel_clk) begin
    exp_t e;
    if (result_valid) begin
      chk("valid_single_cycle", 64'(valid_d), 64'd0);
      if (q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_valid: got result_valid=1 expected no pulse");
      end else begin
        e = q.pop_front();
        chk("wall_top",    64'(wall_top),    64'(e.top));
        chk("wall_bottom", 64'(wall_bottom), 64'(e.bot));
        chk("wall_left",   64'(wall_left),   64'(e.lft));
        chk("wall_right",  64'(wall_right),  64'(e.rgt));
        chk("prev_x",      64'(prev_x),      64'(e.px));
        chk("prev_y",      64'(prev_y),      64'(e.py));
      end
    end
    valid_d = result_valid;
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit w);
    draw_x     = 10'(x);
    draw_y     = 10'(y);
    wall_pixel = w;
    tick();
  endtask

  // (0,0) held three cycles to exercise the one-shot frame start, then a
  // window around the objects (or a few pixels for short frames).
  task automatic scan_frame(input int wx, input int wy, input int chg, input bit short_f);
    for (int k = 0; k < 3; k++) pix(0, 0, 1'b0);
    if (short_f) begin
      if (wx >= 0) pix(wx, wy, 1'b1);
      pix(5, 5, 1'b0);
    end else begin
      for (int y = 92; y <= 108; y++) begin
        if (y == 100 && chg >= 0) obj_x[9:0] = 10'(chg);
        for (int x = 92; x <= 108; x++) pix(x, y, (x == wx) && (y == wy));
      end
    end
    pix(700, 500, 1'b0);
    pix(700, 500, 1'b0);
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.top = {2'b00, v.f1[3], v.f0[3]};
    e.bot = {2'b00, v.f1[2], v.f0[2]};
    e.lft = {2'b00, v.f1[1], v.f0[1]};
    e.rgt = {2'b00, v.f1[0], v.f0[0]};
    e.px  = {20'd0, 10'(v.p1x), 10'(v.p0x)};
    e.py  = {20'd0, 10'(v.p1y), 10'(v.p0y)};
    return e;
  endfunction

  task automatic set_objs(input vec_t v);
    obj_x      = {20'd0, 10'(v.x1), 10'(v.x0)};
    obj_y      = {20'd0, 10'(v.y1), 10'(v.y0)};
    obj_s      = {20'd0, 10'(v.s1), 10'(v.s0)};
    obj_active = {2'b00, v.a1, v.a0};
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_top"},   64'(wall_top),    64'd0);
    chk({tag, "_bot"},   64'(wall_bottom), 64'd0);
    chk({tag, "_left"},  64'(wall_left),   64'd0);
    chk({tag, "_right"}, 64'(wall_right),  64'd0);
    chk({tag, "_prevx"}, 64'(prev_x),      64'd0);
    chk({tag, "_prevy"}, 64'(prev_y),      64'd0);
    chk({tag, "_valid"}, 64'(result_valid), 64'd0);
  endtask

  initial begin
    vec_t vecs[12];
    vec_t v;
    exp_t pend;
    bit   have_pend = 1'b0;

    //          x0  y0  s0 a0  x1  y1  s1 a1   wx   wy  chg   f0       f1      p0x p0y p1x p1y
    vecs[0]  = '{100,100,4,1,   0,  0,0,0,   -1,  -1,  -1, 4'b0000, 4'b0000, 100,100, 0,  0};
    vecs[1]  = '{100,100,4,1,   0,  0,0,0,  100,  96,  -1, 4'b1000, 4'b0000, 100,100, 0,  0};
    vecs[2]  = '{100,100,4,1,   0,  0,0,0,  104, 104,  -1, 4'b0101, 4'b0000, 100,100, 0,  0};
    vecs[3]  = '{100,100,4,1,   2,240,4,1,   -1,  -1,  -1, 4'b0000, 4'b0010, 100,100, 0,  0};
    vecs[4]  = '{100,100,4,1,   2,240,4,0,   -1,  -1,  -1, 4'b0000, 4'b0000, 100,100, 0,  0};
    vecs[5]  = '{100,100,4,1,   0,  0,0,0,  100,  96, 300, 4'b1000, 4'b0000, 100,100, 0,  0};
    vecs[6]  = '{300,100,4,1,   0,  0,0,0,  100,  96,  -1, 4'b0000, 4'b0000, 300,100, 0,  0};
    vecs[7]  = '{320,476,4,1, 636,  4,4,1,   -1,  -1,  -1, 4'b0100, 4'b1001, 300,100, 0,  0};
    vecs[8]  = '{320,474,4,1,   5,  5,4,1,   -1,  -1,  -1, 4'b0000, 4'b0000, 320,474, 5,  5};
    vecs[9]  = '{100,100,4,1,   0,  0,0,0,  105,  96,  -1, 4'b0000, 4'b0000, 100,100, 5,  5};
    vecs[10] = '{100,100,4,1,   0,  0,0,0,   96, 100,  -1, 4'b0010, 4'b0000, 100,100, 5,  5};
    vecs[11] = '{100,100,4,0,   0,  0,0,0,  100,  96,  -1, 4'b0000, 4'b0000, 100,100, 5,  5};

    Reset = 1'b1;
    draw_x = 10'd700; draw_y = 10'd500; wall_pixel = 1'b0;
    obj_x = '0; obj_y = '0; obj_s = '0; obj_active = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check_all_zero("reset");

    // Table: each frame's expectation is queued as the next frame starts.
    for (int i = 0; i < 12; i++) begin
      set_objs(vecs[i]);
      if (have_pend) q.push_back(pend);
      scan_frame(vecs[i].wx, vecs[i].wy, vecs[i].chg, 1'b0);
      pend      = mk_exp(vecs[i]);
      have_pend = 1'b1;
    end

    // Reset mid-frame: partial frame discarded, outputs cleared at once.
    v = vecs[1];
    set_objs(v);
    q.push_back(pend);
    for (int k = 0; k < 3; k++) pix(0, 0, 1'b0);
    for (int y = 150; y <= 200; y += 10) pix(50, y, 1'b0);
    drain("drain_before_reset");
    Reset = 1'b1;
    #2;
    check_all_zero("async_reset");
    tick();
    Reset = 1'b0;
    scan_frame(100, 96, -1, 1'b0);
    v.f0 = 4'b1000; v.p0x = 0; v.p0y = 0; v.p1x = 0; v.p1y = 0;
    q.push_back(mk_exp(v));
    scan_frame(-1, -1, -1, 1'b0);
    drain("drain_after_reset");

`ifdef COLLISION_COUNT_EN
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("count_reset", 64'(hit_count), 64'd0);
    for (int i = 0; i < 301; i++) begin
      if (i > 0) q.push_back(mk_exp(v));
      scan_frame(100, 96, -1, 1'b1);
    end
    q.push_back(mk_exp(v));
    scan_frame(-1, -1, -1, 1'b1);
    drain("drain_count");
    chk("hit_count_sat", 64'(hit_count), 64'h0000_00FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
